// File: rtl/pipeline_stage_memory_access_pkg.sv
// Shared types for the memory-access stage: access size, FSM state and the
// execute fields held while a data-memory access is outstanding.
package pipeline_stage_memory_access_pkg;

  // Build-wide widths; the latched-field struct below is sized from them.
  localparam int DATA_WIDTH   = 32;
  localparam int REG_ID_WIDTH = 5;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   instr;
    logic [DATA_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   store_data;
    logic [REG_ID_WIDTH-1:0] reg_write_id;
    logic                    reg_write_en;
    logic                    mem_read;
    logic                    mem_write;
    mem_size_t               size;
    logic                    mem_signed;
  } ex_fields_t;

endpackage

// File: rtl/pipeline_stage_memory_access_if.sv
// Execute-side, data-memory and write-back signals of the memory-access stage.
// Handshake: execute hands over an instruction on a clock edge where
// ex_valid && ex_ready; a memory access completes on the edge where mem_ack is
// high while mem_req is held; write back consumes every cycle with wb_valid.
interface pipeline_stage_memory_access_if;
  import pipeline_stage_memory_access_pkg::*;

  logic                    ex_valid;
  logic                    ex_ready;
  logic [DATA_WIDTH-1:0]   ex_instr;
  logic [DATA_WIDTH-1:0]   ex_alu_result;
  logic [DATA_WIDTH-1:0]   ex_store_data;
  logic [REG_ID_WIDTH-1:0] ex_reg_write_id;
  logic                    ex_reg_write_en;
  logic                    ex_mem_read;
  logic                    ex_mem_write;
  logic [1:0]              ex_mem_size;
  logic                    ex_mem_signed;

  logic                    mem_req;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [3:0]              mem_be;
  logic                    mem_ack;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  logic                    wb_valid;
  logic [DATA_WIDTH-1:0]   wb_instr;
  logic [REG_ID_WIDTH-1:0] wb_reg_write_id;
  logic                    wb_reg_write_en;
  logic [DATA_WIDTH-1:0]   wb_reg_data;
  logic                    wb_forward_stall;
  logic                    fault;

  modport slave (
    input  ex_valid, ex_instr, ex_alu_result, ex_store_data, ex_reg_write_id,
           ex_reg_write_en, ex_mem_read, ex_mem_write, ex_mem_size, ex_mem_signed,
           mem_ack, mem_rdata,
    output ex_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           wb_valid, wb_instr, wb_reg_write_id, wb_reg_write_en, wb_reg_data,
           wb_forward_stall, fault
  );

  modport master (
    output ex_valid, ex_instr, ex_alu_result, ex_store_data, ex_reg_write_id,
           ex_reg_write_en, ex_mem_read, ex_mem_write, ex_mem_size, ex_mem_signed,
           mem_ack, mem_rdata,
    input  ex_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           wb_valid, wb_instr, wb_reg_write_id, wb_reg_write_en, wb_reg_data,
           wb_forward_stall, fault
  );

endinterface

// File: rtl/pipeline_stage_memory_access_mem_lane_align.sv
// Little-endian byte-lane handling: store replication, byte enables, load
// extraction with zero/sign extension, and misalignment detection.
module pipeline_stage_memory_access_mem_lane_align
  import pipeline_stage_memory_access_pkg::*;
(
  input  logic [1:0]            offset,
  input  mem_size_t             size,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [3:0]            be,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  misaligned
);

  logic [DATA_WIDTH-1:0] shifted;

  // Selected lane moved down to bit 0.
  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    be         = 4'hF;
    wdata      = store_data;
    load_data  = shifted;
    misaligned = 1'b0;
    case (size)
      BYTE: begin
        be        = 4'b0001 << offset;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      end
      HALF: begin
        be         = 4'b0011 << offset;
        wdata      = {2{store_data[15:0]}};
        load_data  = {{16{is_signed & shifted[15]}}, shifted[15:0]};
        misaligned = offset[0];
      end
      default: begin
        misaligned = (offset != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/pipeline_stage_memory_access.sv
// MIPS pipeline stage 4: issues loads/stores over a req/ack data-memory port
// and registers the result into the write-back slot.
module pipeline_stage_memory_access
  import pipeline_stage_memory_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clock,
  input  logic                            reset,
  pipeline_stage_memory_access_if.slave   bus,
  output mem_state_t                      state
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  ex_fields_t              ex_fields;
  ex_fields_t              held;
  ex_fields_t              cur;
  logic [CNT_W-1:0]        count;
  logic [3:0]              be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   load_data;
  logic                    misaligned;
  logic                    is_mem;
  logic                    issue;
  logic                    timeout_hit;

  logic                    wb_valid;
  logic [DATA_WIDTH-1:0]   wb_instr;
  logic [REG_ID_WIDTH-1:0] wb_reg_write_id;
  logic                    wb_reg_write_en;
  logic [DATA_WIDTH-1:0]   wb_reg_data;
  logic                    fault;

  always_comb begin
    ex_fields              = '0;
    ex_fields.instr        = bus.ex_instr;
    ex_fields.addr         = bus.ex_alu_result;
    ex_fields.store_data   = bus.ex_store_data;
    ex_fields.reg_write_id = bus.ex_reg_write_id;
    ex_fields.reg_write_en = bus.ex_reg_write_en;
    ex_fields.mem_read     = bus.ex_mem_read;
    ex_fields.mem_write    = bus.ex_mem_write;
    ex_fields.size         = mem_size_t'(bus.ex_mem_size);
    ex_fields.mem_signed   = bus.ex_mem_signed;
  end

  // While waiting, the request is rebuilt from the held copy so it stays stable.
  assign cur         = (state == WAIT) ? held : ex_fields;
  assign is_mem      = cur.mem_read | cur.mem_write;
  assign issue       = (state == IDLE) && bus.ex_valid && is_mem && !misaligned;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count == LAST_COUNT);

  pipeline_stage_memory_access_mem_lane_align u_mem_lane_align (
    .offset     (cur.addr[1:0]),
    .size       (cur.size),
    .is_signed  (cur.mem_signed),
    .store_data (cur.store_data),
    .rdata      (bus.mem_rdata),
    .be         (be),
    .wdata      (wdata),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  // Gating with reset drops an outstanding request in the reset cycle itself.
  assign bus.mem_req          = !reset && (issue || (state == WAIT));
  assign bus.mem_we           = bus.mem_req && cur.mem_write;
  assign bus.mem_be           = bus.mem_req ? be : 4'b0000;
  assign bus.mem_addr         = {cur.addr[DATA_WIDTH-1:2], 2'b00};
  assign bus.mem_wdata        = wdata;
  assign bus.ex_ready         = !reset && (state == IDLE);
  assign bus.wb_valid         = wb_valid;
  assign bus.wb_instr         = wb_instr;
  assign bus.wb_reg_write_id  = wb_reg_write_id;
  assign bus.wb_reg_write_en  = wb_reg_write_en;
  assign bus.wb_reg_data      = wb_reg_data;
  assign bus.wb_forward_stall = !wb_valid;
  assign bus.fault            = fault;

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      held            <= '0;
      count           <= '0;
      wb_valid        <= 1'b0;
      wb_instr        <= '0;
      wb_reg_write_id <= '0;
      wb_reg_write_en <= 1'b0;
      wb_reg_data     <= '0;
      fault           <= 1'b0;
    end else begin
      wb_valid        <= 1'b0;
      wb_reg_write_en <= 1'b0;
      fault           <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ex_valid) begin
            if (issue) begin
              state <= WAIT;
              held  <= ex_fields;
              count <= '0;
            end else begin
              // ALU result, or a misaligned access retired with its write suppressed.
              wb_valid        <= 1'b1;
              wb_instr        <= cur.instr;
              wb_reg_write_id <= cur.reg_write_id;
              wb_reg_write_en <= cur.reg_write_en && !is_mem;
              wb_reg_data     <= cur.addr;
              fault           <= is_mem;
            end
          end
        end
        WAIT: begin
          if (bus.mem_ack || timeout_hit) begin
            state           <= IDLE;
            wb_valid        <= 1'b1;
            wb_instr        <= cur.instr;
            wb_reg_write_id <= cur.reg_write_id;
            wb_reg_write_en <= bus.mem_ack && cur.mem_read && cur.reg_write_en;
            wb_reg_data     <= (bus.mem_ack && cur.mem_read) ? load_data : cur.addr;
            fault           <= !bus.mem_ack;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pipeline_stage_memory_access.md
Name: pipeline_stage_memory_access

Overview:
Stage 4 of the five-stage MIPS pipeline. Takes the execute-stage result, performs loads and stores through a req/ack data-memory port with variable latency, and registers the result for write back. While a memory access is outstanding it back-pressures execute and presents a bubble (forward-stall flag) to write back.

Parameters:
DATA_WIDTH, 32, word width; address and data width.
REG_ID_WIDTH, 5, register identifier width.
TIMEOUT_CYCLES, 255, maximum wait for mem_ack before an abort; 0 disables the timeout.

Ports:
clock  input  1  stage clock; all state updates on the posedge.
reset  input  1  synchronous, active-high.
ex_valid  input  1  execute presents a valid instruction.
ex_ready  output  1  stage accepts the execute result this cycle.
ex_instr  input  32  raw instruction word, passed through.
ex_alu_result  input  32  ALU result; the byte address for loads and stores.
ex_store_data  input  32  rt value for stores.
ex_reg_write_id  input  5  destination register.
ex_reg_write_en  input  1  instruction writes a register.
ex_mem_read  input  1  load.
ex_mem_write  input  1  store; never asserted together with ex_mem_read.
ex_mem_size  input  2  0 = byte, 1 = half, 2 = word.
ex_mem_signed  input  1  sign-extend the load result.
mem_req  output  1  memory request.
mem_we  output  1  write request.
mem_addr  output  32  word-aligned address (low 2 bits zero).
mem_wdata  output  32  lane-shifted store data.
mem_be  output  4  byte enables.
mem_ack  input  1  one-cycle completion pulse.
mem_rdata  input  32  read data, valid when mem_ack = 1.
wb_valid  output  1  write-back slot holds a real instruction.
wb_instr  output  32  instruction in the write-back slot.
wb_reg_write_id  output  5  destination register.
wb_reg_write_en  output  1  register write enable.
wb_reg_data  output  32  value to write.
wb_forward_stall  output  1  slot is a bubble; write back must suppress the register write.
fault  output  1  one-cycle pulse on a misaligned access or a timeout.

Behaviour:
- Reset: state IDLE. wb_valid = 0, wb_forward_stall = 1, wb_reg_write_en = 0, wb_instr = 0, wb_reg_data = 0, wb_reg_write_id = 0. mem_req = 0, mem_we = 0, mem_be = 0, fault = 0, timeout counter = 0. Reset mid-access drops the request immediately. A late mem_ack after reset is ignored.
- FSM states: IDLE and WAIT.
- IDLE, ex_ready = 1.
  - Non-memory instruction with ex_valid: registered to the write-back slot next cycle with wb_reg_data = ex_alu_result. Latency is 1.
  - Load or store: the request is driven combinationally in the same cycle. The FSM goes to WAIT and the execute fields are latched. The write-back slot becomes a bubble.
- WAIT: ex_ready = 0. mem_req, mem_we, mem_addr, mem_wdata and mem_be are held stable until mem_ack.
  - On mem_ack the slot is filled next cycle: load data for loads, wb_reg_write_en = 0 for stores. The FSM returns to IDLE.
  - Minimum load/store latency is 2 cycles, issue to write-back.
- Byte lanes (little-endian, a = addr[1:0]):
  - Byte: be = 1 << a, wdata = the byte replicated 4 times.
  - Half: be = 3 << a, wdata = the half replicated twice.
  - Word: be = 4'hF.
  - Loads extract the selected lane and then zero- or sign-extend it.
- Misalignment: a half access with a[0] = 1, or a word access with a != 0, issues no request. fault pulses, and the slot receives the instruction with wb_reg_write_en = 0.
- Timeout: the counter increments each WAIT cycle. When it reaches TIMEOUT_CYCLES: fault pulses, the request drops, the slot gets the instruction with the write suppressed, and the FSM returns to IDLE.
- mem_ack arriving while in IDLE is ignored.
- ex_valid = 0 in IDLE: a bubble. wb_valid = 0, wb_forward_stall = 1.
- wb_forward_stall = !wb_valid, always.
- Instructions are never dropped or duplicated: every accepted ex_valid produces exactly one wb_valid cycle.

Decomposition:
- Shared package gets:
  - the mem_size_t enum (BYTE, HALF, WORD),
  - the mem_state_t enum (IDLE, WAIT),
  - a packed struct for the latched execute fields.
- Natural sub-module: mem_lane_align. It is purely combinational and holds the store lane shift, the byte-enable generation, the load extraction/extension and the misalignment detect.

Test Plan:
- ALU op with ex_alu_result = 0x1234, write to r8 -> one cycle later wb_valid = 1, wb_reg_data = 0x1234, wb_reg_write_id = 8, ex_ready stays 1.
- Signed byte load at address 0x103, mem_rdata = 0x80FF_FF7F with a 3-cycle ack delay -> ex_ready = 0 for 3 cycles, mem_addr = 0x100, mem_be = 4'b1000, then wb_reg_data = 0xFFFF_FF80.
- Half store at 0x202 with data 0xABCD -> mem_be = 4'b1100, mem_wdata = 0xABCD_ABCD, mem_we = 1; write-back slot has wb_reg_write_en = 0.
- Word load at 0x301 -> no mem_req, fault for 1 cycle, wb_valid = 1 with wb_reg_write_en = 0.
- TIMEOUT_CYCLES = 4, no ack -> fault on the 4th WAIT cycle, mem_req drops, FSM back in IDLE, the next instruction is accepted.
- Reset asserted during WAIT, then mem_ack pulses the following cycle -> all outputs return to reset values and no write-back slot is produced.
